// File: rtl/i2c_reg_sequencer.sv
// i2c_reg_sequencer: drives an OpenCores-style i2c_master core over its 8-bit
// register port. It programs the prescaler, enables the core, and then runs
// single-byte register write/read transactions for a host, reporting NACK and
// poll timeouts.
module i2c_reg_sequencer #(
    parameter logic [15:0] PRESCALE   = 16'd39,
    parameter int          POLL_LIMIT = 1023
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_req,
    input  logic       i_rw,
    input  logic [6:0] i_dev_addr,
    input  logic [7:0] i_reg_addr,
    input  logic [7:0] i_wdata,
    output logic       o_busy,
    output logic       o_done,
    output logic [1:0] o_err,
    output logic [7:0] o_rdata,
    output logic       o_ren,
    output logic       o_wren,
    output logic [2:0] o_addr,
    output logic [7:0] o_data,
    input  logic [7:0] i_data,
    input  logic       i_data_val,
    input  logic       i_done
);

    localparam int               CNT_W     = $clog2(POLL_LIMIT + 2);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(POLL_LIMIT);

    // Core register map
    localparam logic [2:0] REG_PRERLO = 3'd0;
    localparam logic [2:0] REG_PRERHI = 3'd1;
    localparam logic [2:0] REG_CTR    = 3'd2;
    localparam logic [2:0] REG_TXRX   = 3'd3;
    localparam logic [2:0] REG_CRSR   = 3'd4;

    // Command / control byte values
    localparam logic [7:0] CTR_EN         = 8'h80;
    localparam logic [7:0] CR_STA_WR      = 8'h90;
    localparam logic [7:0] CR_WR          = 8'h10;
    localparam logic [7:0] CR_STO_WR      = 8'h50;
    localparam logic [7:0] CR_RD_NACK_STO = 8'h68;
    localparam logic [7:0] CR_STO         = 8'h40;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_NACK    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [3:0] {
        S_INIT_PRLO,
        S_INIT_PRHI,
        S_INIT_CTR,
        S_IDLE,
        S_TXR,
        S_CR,
        S_POLL,
        S_RXR,
        S_ABORT,
        S_FINISH
    } state_e;

    state_e           state_q, state_d;
    logic             issued_q, issued_d;   // a bus op is outstanding
    logic [1:0]       step_q, step_d;       // byte index within the transaction
    logic             rw_q, rw_d;
    logic [6:0]       dev_q, dev_d;
    logic [7:0]       reg_q, reg_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tip_q, tip_d;
    logic             rxack_q, rxack_d;
    logic [1:0]       err_code_q, err_code_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [1:0]       err_q, err_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             ren_q, ren_d;
    logic             wren_q, wren_d;
    logic [2:0]       addr_q, addr_d;
    logic [7:0]       data_q, data_d;

    logic       want_wr, want_rd;
    logic [2:0] op_addr;
    logic [7:0] op_data;
    logic [7:0] txr_byte, cr_byte;
    logic       op_done, sr_tip, sr_rxack;

    assign op_done  = issued_q && i_done;
    // SR may arrive in the same cycle as i_done, so prefer the live value.
    assign sr_tip   = i_data_val ? i_data[1] : tip_q;
    assign sr_rxack = i_data_val ? i_data[7] : rxack_q;

    // TXR and CR bytes for the current transaction step
    always_comb begin
        txr_byte = 8'h00;
        cr_byte  = CR_RD_NACK_STO;
        case (step_q)
            2'd0: begin
                txr_byte = {dev_q, 1'b0};
                cr_byte  = CR_STA_WR;
            end
            2'd1: begin
                txr_byte = reg_q;
                cr_byte  = CR_WR;
            end
            2'd2: begin
                txr_byte = rw_q ? {dev_q, 1'b1} : wdata_q;
                cr_byte  = rw_q ? CR_STA_WR : CR_STO_WR;
            end
            default: begin
                txr_byte = 8'h00;
                cr_byte  = CR_RD_NACK_STO;
            end
        endcase
    end

    // Next-state and output logic
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_d    = state_q;
        issued_d   = issued_q;
        step_d     = step_q;
        rw_d       = rw_q;
        dev_d      = dev_q;
        reg_d      = reg_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        tip_d      = tip_q;
        rxack_d    = rxack_q;
        err_code_d = err_code_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        rdata_d    = rdata_q;
        ren_d      = 1'b0;
        wren_d     = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        want_wr    = 1'b0;
        want_rd    = 1'b0;
        op_addr    = addr_q;
        op_data    = data_q;

        if (op_done) begin
            issued_d = 1'b0;
        end

        case (state_q)
            S_INIT_PRLO: begin
                want_wr = 1'b1;
                op_addr = REG_PRERLO;
                op_data = PRESCALE[7:0];
                if (op_done) state_d = S_INIT_PRHI;
            end
            S_INIT_PRHI: begin
                want_wr = 1'b1;
                op_addr = REG_PRERHI;
                op_data = PRESCALE[15:8];
                if (op_done) state_d = S_INIT_CTR;
            end
            S_INIT_CTR: begin
                want_wr = 1'b1;
                op_addr = REG_CTR;
                op_data = CTR_EN;
                if (op_done) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                // Hold off for the o_done cycle so a new request lands one cycle later.
                if (i_req && !done_q) begin
                    rw_d       = i_rw;
                    dev_d      = i_dev_addr;
                    reg_d      = i_reg_addr;
                    wdata_d    = i_wdata;
                    busy_d     = 1'b1;
                    err_d      = ERR_OK;
                    err_code_d = ERR_OK;
                    step_d     = 2'd0;
                    state_d    = S_TXR;
                end
            end
            S_TXR: begin
                want_wr = 1'b1;
                op_addr = REG_TXRX;
                op_data = txr_byte;
                if (op_done) state_d = S_CR;
            end
            S_CR: begin
                want_wr = 1'b1;
                op_addr = REG_CRSR;
                op_data = cr_byte;
                if (op_done) begin
                    cnt_d   = '0;
                    state_d = S_POLL;
                end
            end
            S_POLL: begin
                want_rd = 1'b1;
                op_addr = REG_CRSR;
                if (issued_q && i_data_val) begin
                    tip_d   = i_data[1];
                    rxack_d = i_data[7];
                end
                if (op_done) begin
                    cnt_d = cnt_q + 1'b1;
                    if (sr_tip) begin
                        if (cnt_q >= CNT_LIMIT) begin
                            err_code_d = ERR_TIMEOUT;
                            state_d    = S_ABORT;
                        end
                    end else if (step_q != 2'd3 && sr_rxack) begin
                        err_code_d = ERR_NACK;
                        state_d    = S_ABORT;
                    end else if (!rw_q && step_q == 2'd2) begin
                        state_d = S_FINISH;
                    end else if (step_q == 2'd3) begin
                        state_d = S_RXR;
                    end else begin
                        step_d  = step_q + 2'd1;
                        // The final read byte has no TXR load, only a command.
                        state_d = (step_q == 2'd2) ? S_CR : S_TXR;
                    end
                end
            end
            S_RXR: begin
                want_rd = 1'b1;
                op_addr = REG_TXRX;
                if (issued_q && i_data_val) rdata_d = i_data;
                if (op_done) state_d = S_FINISH;
            end
            S_ABORT: begin
                want_wr = 1'b1;
                op_addr = REG_CRSR;
                op_data = CR_STO;
                if (op_done) state_d = S_FINISH;
            end
            S_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                err_d   = err_code_q;
                state_d = S_IDLE;
            end
            default: state_d = S_INIT_PRLO;
        endcase

        // Issue a new op only when none is outstanding; the cycle that sees
        // i_done clears issued, so the next pulse comes a cycle later.
        if (!issued_q && (want_wr || want_rd)) begin
            wren_d   = want_wr;
            ren_d    = want_rd;
            addr_d   = op_addr;
            data_d   = op_data;
            issued_d = 1'b1;
        end
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= S_INIT_PRLO;
            issued_q   <= 1'b0;
            step_q     <= 2'd0;
            rw_q       <= 1'b0;
            dev_q      <= 7'd0;
            reg_q      <= 8'd0;
            wdata_q    <= 8'd0;
            cnt_q      <= '0;
            tip_q      <= 1'b0;
            rxack_q    <= 1'b0;
            err_code_q <= ERR_OK;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= ERR_OK;
            rdata_q    <= 8'd0;
            ren_q      <= 1'b0;
            wren_q     <= 1'b0;
            addr_q     <= 3'd0;
            data_q     <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            issued_q   <= issued_d;
            step_q     <= step_d;
            rw_q       <= rw_d;
            dev_q      <= dev_d;
            reg_q      <= reg_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            tip_q      <= tip_d;
            rxack_q    <= rxack_d;
            err_code_q <= err_code_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            ren_q      <= ren_d;
            wren_q     <= wren_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign o_err   = err_q;
    assign o_rdata = rdata_q;
    assign o_ren   = ren_q;
    assign o_wren  = wren_q;
    assign o_addr  = addr_q;
    assign o_data  = data_q;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Directed bench for i2c_reg_sequencer with a behavioural i2c_master port
// model that logs every bus op and answers SR/RXR reads.
module tb_i2c_reg_sequencer;

    localparam int LOG_SZ = 8192;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       req   = 1'b0;
    logic       rw    = 1'b0;
    logic [6:0] dev   = 7'd0;
    logic [7:0] rg    = 8'd0;
    logic [7:0] wd    = 8'd0;
    logic       busy, done, ren, wren;
    logic [1:0] err;
    logic [7:0] rdata, wdat;
    logic [2:0] addr;
    logic [7:0] ctl_data = 8'd0;
    logic       ctl_val  = 1'b0;
    logic       ctl_done = 1'b0;

    always #5 clk = ~clk;

    i2c_reg_sequencer dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_req      (req),
        .i_rw       (rw),
        .i_dev_addr (dev),
        .i_reg_addr (rg),
        .i_wdata    (wd),
        .o_busy     (busy),
        .o_done     (done),
        .o_err      (err),
        .o_rdata    (rdata),
        .o_ren      (ren),
        .o_wren     (wren),
        .o_addr     (addr),
        .o_data     (wdat),
        .i_data     (ctl_data),
        .i_data_val (ctl_val),
        .i_done     (ctl_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Model configuration (written by the stimulus process only)
    int         tip_count = 2;
    int         nack_at   = -1;
    bit         stuck     = 1'b0;
    logic [7:0] rxr_val   = 8'h00;

    // Model state and op log (written by the model process only)
    int         log_n      = 0;
    int         cr_total   = 0;
    int         violations = 0;
    logic       log_wr   [LOG_SZ];
    logic [2:0] log_addr [LOG_SZ];
    logic [7:0] log_data [LOG_SZ];

    logic [10:0] exp_w[$];

    // Controller model: i_done two negedges after a pulse, SR/RXR answers
    initial begin : ctl_model
        bit         pending, p_rd, done_was, was_pending;
        int         delay, tip_left;
        logic [7:0] resp;
        pending  = 1'b0;
        p_rd     = 1'b0;
        delay    = 0;
        tip_left = 0;
        resp     = 8'h00;
        forever begin
            @(negedge clk);
            done_was    = ctl_done;
            was_pending = pending;
            ctl_done    = 1'b0;
            ctl_val     = 1'b0;
            if (!rst_n) begin
                pending = 1'b0;
            end else begin
                if (pending) begin
                    if (delay == 0) begin
                        ctl_done = 1'b1;
                        if (p_rd) begin
                            ctl_data = resp;
                            ctl_val  = 1'b1;
                        end
                        pending = 1'b0;
                    end else begin
                        delay--;
                    end
                end
                if (wren || ren) begin
                    if (done_was || was_pending || (wren && ren)) violations++;
                    if (log_n < LOG_SZ) begin
                        log_wr[log_n]   = wren;
                        log_addr[log_n] = addr;
                        log_data[log_n] = wdat;
                    end
                    log_n++;
                    if (wren && addr == 3'd4) begin
                        cr_total++;
                        tip_left = tip_count;
                    end
                    if (ren && addr == 3'd4) begin
                        if (stuck) begin
                            resp = 8'h02;
                        end else if (tip_left > 0) begin
                            tip_left--;
                            resp = 8'h02;
                        end else begin
                            resp = (cr_total - 1 == nack_at) ? 8'h80 : 8'h00;
                        end
                    end else if (ren && addr == 3'd3) begin
                        resp = rxr_val;
                    end else begin
                        resp = 8'hEE;
                    end
                    pending = 1'b1;
                    delay   = 1;
                    p_rd    = ren;
                end
            end
        end
    end

    // Compare the logged writes from base onward with exp_w, plus read counts
    task automatic verify_ops(input string tag, input int base, input int exp_sr, input int exp_rx);
        logic [10:0] got_w[$];
        int n_sr = 0;
        int n_rx = 0;
        for (int i = base; i < log_n && i < LOG_SZ; i++) begin
            if (log_wr[i])              got_w.push_back({log_addr[i], log_data[i]});
            else if (log_addr[i] == 3'd4) n_sr++;
            else if (log_addr[i] == 3'd3) n_rx++;
        end
        check({tag, "_nwr"}, got_w.size(), exp_w.size());
        for (int i = 0; i < exp_w.size(); i++) begin
            check($sformatf("%s_w%0d", tag, i), (i < got_w.size()) ? got_w[i] : 11'h7FF, exp_w[i]);
        end
        check({tag, "_sr_reads"}, n_sr, exp_sr);
        check({tag, "_rxr_reads"}, n_rx, exp_rx);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  busy,  1'b1);
        check({tag, "_done"},  done,  1'b0);
        check({tag, "_ren"},   ren,   1'b0);
        check({tag, "_wren"},  wren,  1'b0);
        check({tag, "_err"},   err,   2'b00);
        check({tag, "_rdata"}, rdata, 8'h00);
        check({tag, "_addr"},  addr,  3'd0);
        check({tag, "_data"},  wdat,  8'h00);
    endtask

    task automatic wait_init(input string tag);
        int k = 0;
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_init_timeout"}, busy, 1'b0);
    endtask

    // One host transaction; optionally pulses i_req mid-flight to test it is ignored
    task automatic run_txn(input string tag, input logic t_rw, input logic [6:0] t_dev,
                           input logic [7:0] t_reg, input logic [7:0] t_wd, input bit inject,
                           input logic [1:0] exp_err, input logic [7:0] exp_rdata);
        int k = 0;
        @(negedge clk);
        req = 1'b1; rw = t_rw; dev = t_dev; rg = t_reg; wd = t_wd;
        @(negedge clk);
        req = 1'b0; rw = ~t_rw; dev = 7'h7F; rg = 8'hFF; wd = 8'h3C;
        check({tag, "_busy_after_req"}, busy, 1'b1);
        while (!done && k < 20000) begin
            @(negedge clk);
            k++;
            if (inject && k == 30) req = 1'b1;
            if (inject && k == 31) req = 1'b0;
        end
        check({tag, "_done_seen"}, done, 1'b1);
        check({tag, "_busy_at_done"}, busy, 1'b0);
        check({tag, "_err"}, err, exp_err);
        check({tag, "_rdata"}, rdata, exp_rdata);
    endtask

    initial begin : stimulus
        int base;
        int k;

        // 1. reset values and init sequence
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("init_busy_high", busy, 1'b1);
        wait_init("t1");
        exp_w = {11'h027, 11'h100, 11'h280};
        verify_ops("t1", 0, 0, 0);

        // 2. write with ACK; i_req pulsed while busy must be ignored
        base = log_n;
        tip_count = 2; nack_at = -1; stuck = 1'b0;
        run_txn("t2", 1'b0, 7'h50, 8'h12, 8'hA5, 1'b1, 2'b00, 8'h00);
        exp_w = {11'h3A0, 11'h490, 11'h312, 11'h410, 11'h3A5, 11'h450};
        verify_ops("t2", base, 9, 0);
        base = log_n;
        repeat (10) @(negedge clk);
        check("t6_ignored_req_no_ops", log_n - base, 0);
        check("t6_ignored_req_idle", busy, 1'b0);

        // 3. read; the RxACK=1 after the final NACKed byte must not abort
        base = log_n;
        rxr_val = 8'h5C; nack_at = cr_total + 3;
        run_txn("t3", 1'b1, 7'h50, 8'h34, 8'h00, 1'b0, 2'b00, 8'h5C);
        exp_w = {11'h3A0, 11'h490, 11'h334, 11'h410, 11'h3A1, 11'h490, 11'h468};
        verify_ops("t3", base, 12, 1);

        // 4. NACK on the address byte
        base = log_n;
        nack_at = cr_total;
        run_txn("t4", 1'b0, 7'h50, 8'h12, 8'hA5, 1'b0, 2'b01, 8'h5C);
        exp_w = {11'h3A0, 11'h490, 11'h440};
        verify_ops("t4", base, 3, 0);

        // 5. timeout: SR stuck busy
        base = log_n;
        nack_at = -1; stuck = 1'b1;
        run_txn("t5", 1'b0, 7'h50, 8'h12, 8'hA5, 1'b0, 2'b10, 8'h5C);
        exp_w = {11'h3A0, 11'h490, 11'h440};
        verify_ops("t5", base, 1024, 0);

        // 6. asynchronous reset mid-poll, then init repeats
        @(negedge clk);
        req = 1'b1; rw = 1'b0; dev = 7'h50; rg = 8'h12; wd = 8'hA5;
        @(negedge clk);
        req = 1'b0;
        k = 0;
        while (!(ren && addr == 3'd4) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("t6_reached_poll", ren, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("t6_async_rst");
        stuck = 1'b0;
        repeat (3) @(negedge clk);
        base = log_n;
        rst_n = 1'b1;
        wait_init("t6");
        exp_w = {11'h027, 11'h100, 11'h280};
        verify_ops("t6_reinit", base, 0, 0);

        check("protocol_violations", violations, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_reg_sequencer.md
Name: i2c_reg_sequencer

Overview:
Sequences complete I2C register transactions over the 8-bit wishbone-style command port of the I2C master controller (one 1-cycle i_ren/i_wren pulse, then wait for o_done). The target is an OpenCores-style i2c_master core: PRERlo=0, PRERhi=1, CTR=2, TXR/RXR=3, CR/SR=4.
- After reset, programs the prescaler and enables the core.
- Then serves single-byte register write and read requests from a host FSM.
- Reports NACK and timeout errors back to the host FSM.

Parameters:
PRESCALE, 16'd39, value written to PRERhi:PRERlo (SCL = clk/(5*(PRESCALE+1))).
POLL_LIMIT, 1023, maximum SR reads per byte before a timeout is declared.

Ports:
i_clk  input  1  system clock
i_reset_n  input  1  asynchronous active-low reset
i_req  input  1  transaction request, sampled only in IDLE
i_rw  input  1  1=read, 0=write
i_dev_addr  input  7  I2C device address
i_reg_addr  input  8  device register address
i_wdata  input  8  write data
o_busy  output  1  high from reset until end of init, and during a transaction
o_done  output  1  1-cycle pulse at end of a transaction
o_err  output  2  00 ok, 01 NACK, 10 timeout; valid with o_done, held until next accept
o_rdata  output  8  read data; valid with o_done, held until next accept
o_ren  output  1  controller read pulse
o_wren  output  1  controller write pulse
o_addr  output  3  controller register address
o_data  output  8  controller write data
i_data  input  8  controller read data
i_data_val  input  1  controller read-data valid
i_done  input  1  controller access complete

Behaviour:
- Clock and reset: single clock i_clk. Reset is asynchronous, active-low (i_reset_n); all flops are cleared asynchronously.
- Reset values:
  - state=INIT_PRLO, o_busy=1.
  - o_done, o_ren, o_wren = 0.
  - o_err, o_rdata, o_addr, o_data = 0.
  - poll counter = 0.
- Bus-op primitive:
  - Drive o_addr/o_data and pulse o_wren or o_ren for exactly one cycle.
  - Hold o_addr/o_data stable until i_done.
  - No new pulse is issued in the same cycle as i_done; the next op is issued at the earliest on the cycle after i_done.
  - For reads, capture i_data when i_data_val=1.
- Init sequence: write PRERlo=PRESCALE[7:0], then PRERhi=PRESCALE[15:8], then CTR=0x80, then go to IDLE with o_busy=0.
- IDLE:
  - On i_req=1, latch i_rw, i_dev_addr, i_reg_addr, i_wdata.
  - Set o_busy=1 the next cycle; clear o_err.
  - i_req while busy is ignored; there is no queue.
- POLL (after every CR write):
  - Read SR repeatedly until SR[1] (TIP) = 0, then check SR[7] (RxACK).
  - RxACK=1 means NACK: go to ABORT with err=01.
  - Read count > POLL_LIMIT: go to ABORT with err=10.
  - The poll counter resets per byte.
- Write transaction:
  1. TXR={dev,0}, CR=0x90 (STA|WR), POLL.
  2. TXR=reg, CR=0x10, POLL.
  3. TXR=wdata, CR=0x50 (STO|WR), POLL.
  4. FINISH.
- Read transaction:
  1. TXR={dev,0}, CR=0x90, POLL.
  2. TXR=reg, CR=0x10, POLL.
  3. TXR={dev,1}, CR=0x90 (repeated start), POLL.
  4. CR=0x68 (RD|NACK|STO), POLL with the RxACK check skipped.
  5. Read RXR into o_rdata.
  6. FINISH.
- ABORT: write CR=0x40 (STO) and wait for i_done only, with no poll. Then FINISH with the latched error code.
- FINISH:
  - o_done=1 for one cycle, o_busy=0 in the same cycle, return to IDLE.
  - A new i_req is accepted on the cycle after o_done.
- Reset mid-transaction: abandon immediately and restart the init sequence. The slave bus may be left un-STOPped; this is acceptable because the core is re-enabled.
- A stray i_done with no op outstanding is ignored.

Test Plan:
1. Release reset with PRESCALE=39 -> wrens at addr 0/1/2 with data 0x27/0x00/0x80, in order; then o_busy=0.
2. Write dev=0x50, reg=0x12, data=0xA5, slave ACKs (SR model returns TIP=1 twice, then 0x00) -> TXR/CR sequence 0xA0/0x90, 0x12/0x10, 0xA5/0x50; o_done pulse; o_err=00.
3. Read dev=0x50, reg=0x34, RXR=0x5C -> CR sequence 0x90,0x10,0x90,0x68; third TXR=0xA1; o_rdata=0x5C; o_err=00.
4. NACK: SR returns 0x80 after the address byte -> CR=0x40 written next, no reg byte sent; o_err=01.
5. Timeout: SR stuck at 0x02 -> exactly POLL_LIMIT+1 SR reads, then CR=0x40; o_err=10.
6. i_req pulsed while busy is ignored. Deassert i_reset_n mid-poll -> outputs return to reset values asynchronously and the init sequence repeats.
